// File: rtl/layer_5_maxpool.sv
// layer_5_maxpool: 2x2 stride-2 max-pooling of one raster-ordered fp32 feature-map stream.
// Pixels arrive one per valid beat. Pooled pixels leave one cycle after the
// odd-row/odd-col beat that completes each 2x2 window.
// Optional feature macro: LAYER5_FRAME_DONE_EN adds a frame_done pulse on the
// last pooled pixel of each frame.
module layer_5_maxpool #(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_SIZE   = 104
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out
`ifdef LAYER5_FRAME_DONE_EN
   ,
   output logic                  frame_done
`endif
);

   localparam int CW   = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
   localparam int HALF = IMG_SIZE / 2;
   localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

   if ((IMG_SIZE < 2) || ((IMG_SIZE % 2) != 0)) begin : g_bad_img_size
      $error("layer_5_maxpool: IMG_SIZE must be even and at least 2");
   end

   // Bitwise fp32 ordering; 'early' wins ties, and +0/-0 count as equal.
   function automatic logic [DATA_WIDTH-1:0] fp_max(
      input logic [DATA_WIDTH-1:0] early,
      input logic [DATA_WIDTH-1:0] late
   );
      logic [DATA_WIDTH-2:0] mag_e;
      logic [DATA_WIDTH-2:0] mag_l;
      logic                  late_wins;
      mag_e = early[DATA_WIDTH-2:0];
      mag_l = late[DATA_WIDTH-2:0];
      if ((mag_e == '0) && (mag_l == '0))
         late_wins = 1'b0;
      else if (early[DATA_WIDTH-1] != late[DATA_WIDTH-1])
         late_wins = ~late[DATA_WIDTH-1];
      else if (!late[DATA_WIDTH-1])
         late_wins = (mag_l > mag_e);
      else
         late_wins = (mag_l < mag_e);
      return late_wins ? late : early;
   endfunction

   logic [CW-1:0]         col;
   logic [CW-1:0]         row;
   logic [DATA_WIDTH-1:0] hold_reg;
   logic [DATA_WIDTH-1:0] linebuf [HALF];
   logic [AW-1:0]         lb_idx;
   logic [DATA_WIDTH-1:0] hmax;
   logic                  pair_done;

   assign lb_idx    = AW'(col >> 1);
   assign hmax      = fp_max(hold_reg, data_in);
   assign pair_done = valid_in && col[0];

   // Raster position of the next accepted pixel; wraps per row and per frame.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         col <= '0;
         row <= '0;
      end else if (valid_in) begin
         if (col == LAST) begin
            col <= '0;
            row <= (row == LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Left pixel of each horizontal pair waits here for its partner.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         hold_reg <= '0;
      else if (valid_in && !col[0])
         hold_reg <= data_in;
   end

   // Even-row horizontal maxima, read back when the odd row below arrives.
   always_ff @(posedge Clk) begin
      if (pair_done && !row[0])
         linebuf[lb_idx] <= hmax;
   end

   // Odd-row pair closes a 2x2 window: register the pooled pixel.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         data_out  <= '0;
         valid_out <= 1'b0;
      end else if (pair_done && row[0]) begin
         data_out  <= fp_max(linebuf[lb_idx], hmax);
         valid_out <= 1'b1;
      end else begin
         valid_out <= 1'b0;
      end
   end

`ifdef LAYER5_FRAME_DONE_EN
   // Flag the pooled pixel produced by the bottom-right input pixel.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         frame_done <= 1'b0;
      else
         frame_done <= valid_in && (col == LAST) && (row == LAST);
   end
`endif

endmodule

// File: tb/tb_layer_5_maxpool.sv
// Bench for layer_5_maxpool: three instances (IMG_SIZE 4, 2 and 104).
module tb_layer_5_maxpool;

   logic        Clk;
   logic        rst_n    [3];
   logic [31:0] din      [3];
   logic        vin      [3];
   wire  [31:0] dout     [3];
   wire         vout     [3];
`ifdef LAYER5_FRAME_DONE_EN
   wire         fd       [3];
`endif
   logic [31:0] last_out [3];

   int checks   = 0;
   int failures = 0;

   logic [31:0] fv [16];
   logic [31:0] pix_q [$];
   logic [31:0] exp_q [$];

   typedef struct {
      logic [31:0] p0;
      logic [31:0] p1;
      logic [31:0] p2;
      logic [31:0] p3;
      logic [31:0] expv;
   } vec_t;
   vec_t tbl [7];

   layer_5_maxpool #(.DATA_WIDTH(32), .IMG_SIZE(4)) u_pool4 (
      .Clk(Clk), .Rst(rst_n[0]), .data_in(din[0]), .valid_in(vin[0]),
      .data_out(dout[0]), .valid_out(vout[0])
`ifdef LAYER5_FRAME_DONE_EN
      , .frame_done(fd[0])
`endif
   );

   layer_5_maxpool #(.DATA_WIDTH(32), .IMG_SIZE(2)) u_pool2 (
      .Clk(Clk), .Rst(rst_n[1]), .data_in(din[1]), .valid_in(vin[1]),
      .data_out(dout[1]), .valid_out(vout[1])
`ifdef LAYER5_FRAME_DONE_EN
      , .frame_done(fd[1])
`endif
   );

   layer_5_maxpool #(.DATA_WIDTH(32), .IMG_SIZE(104)) u_pool104 (
      .Clk(Clk), .Rst(rst_n[2]), .data_in(din[2]), .valid_in(vin[2]),
      .data_out(dout[2]), .valid_out(vout[2])
`ifdef LAYER5_FRAME_DONE_EN
      , .frame_done(fd[2])
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, expv);
      end
   endtask

   // Total order on bit patterns: negatives by decreasing magnitude, zeros equal.
   function automatic longint fkey(input logic [31:0] x);
      longint m;
      m = longint'(x[30:0]);
      return x[31] ? -m : m;
   endfunction

   function automatic logic [31:0] later_max(input logic [31:0] a, input logic [31:0] b);
      return (fkey(b) > fkey(a)) ? b : a;
   endfunction

   // Expected pooled frame from the n x n frame in pix_q.
   function automatic void build_expect(input int n);
      logic [31:0] top;
      logic [31:0] bot;
      exp_q.delete();
      for (int i = 0; i < n / 2; i++)
         for (int j = 0; j < n / 2; j++) begin
            top = later_max(pix_q[(2*i)*n + 2*j], pix_q[(2*i)*n + 2*j + 1]);
            bot = later_max(pix_q[(2*i+1)*n + 2*j], pix_q[(2*i+1)*n + 2*j + 1]);
            exp_q.push_back(later_max(top, bot));
         end
   endfunction

   // One clock: drive, let the edge consume it, then check outputs just after.
   task automatic beat(input int d, input logic v, input logic [31:0] x,
                       input logic ev, input logic [31:0] ed, input logic efd,
                       input string nm);
      vin[d] = v;
      din[d] = x;
      @(posedge Clk);
      #1;
      vin[d] = 1'b0;
      if (ev) last_out[d] = ed;
      chk({nm, " valid_out"}, 32'(vout[d]), 32'(ev));
      chk({nm, " data_out"}, dout[d], last_out[d]);
`ifdef LAYER5_FRAME_DONE_EN
      chk({nm, " frame_done"}, 32'(fd[d]), 32'(efd));
`else
      if (efd && !ev) $display("note: frame_done expectation without valid");
`endif
   endtask

   // gap >= 0: fixed idle cycles after each beat; gap < 0: random idle cycles.
   task automatic run_frame(input int d, input int n, input int gap, input string nm);
      int          k;
      int          g;
      int          r;
      int          c;
      logic        ev;
      logic [31:0] ed;
      k = 0;
      for (int i = 0; i < n * n; i++) begin
         r  = i / n;
         c  = i % n;
         ev = ((r % 2) == 1) && ((c % 2) == 1);
         ed = 32'h0;
         if (ev) ed = exp_q[k];
         beat(d, 1'b1, pix_q[i], ev, ed, ev && (k == (n * n) / 4 - 1), nm);
         if (ev) k++;
         if (gap >= 0) g = gap;
         else g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
         for (int j = 0; j < g; j++)
            beat(d, 1'b0, $urandom, 1'b0, 32'h0, 1'b0, nm);
      end
   endtask

   task automatic load_basic();
      pix_q.delete();
      for (int i = 0; i < 16; i++) pix_q.push_back(fv[i]);
      exp_q = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
   endtask

   initial begin
      fv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
             32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
             32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
      tbl[0] = '{32'hBF800000, 32'hBF000000, 32'hC0000000, 32'hC0400000, 32'hBF000000};
      tbl[1] = '{32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00000000};
      tbl[2] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000, 32'h40400000};
      tbl[3] = '{32'hBF800000, 32'h3F800000, 32'hC0A00000, 32'hC0C00000, 32'h3F800000};
      tbl[4] = '{32'h7F800000, 32'h3F800000, 32'hFF800000, 32'h00000001, 32'h7F800000};
      tbl[5] = '{32'hFF800000, 32'hC0000000, 32'hFF800000, 32'hC1200000, 32'hC0000000};
      tbl[6] = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000003};

      for (int d = 0; d < 3; d++) begin
         rst_n[d]    = 1'b0;
         vin[d]      = 1'b0;
         din[d]      = 32'h0;
         last_out[d] = 32'h0;
      end
      repeat (2) @(posedge Clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("reset valid_out", 32'(vout[d]), 32'h0);
         chk("reset data_out", dout[d], 32'h0);
`ifdef LAYER5_FRAME_DONE_EN
         chk("reset frame_done", 32'(fd[d]), 32'h0);
`endif
         rst_n[d] = 1'b1;
      end

      // Basic pool, continuous valid.
      load_basic();
      run_frame(0, 4, 0, "basic");

      // Same frame with 3 idle cycles after every beat.
      load_basic();
      run_frame(0, 4, 3, "gaps");

      // Back-to-back frames, second one negated.
      load_basic();
      run_frame(0, 4, 0, "b2b_f1");
      pix_q.delete();
      for (int i = 0; i < 16; i++) pix_q.push_back(fv[i] ^ 32'h80000000);
      exp_q = '{32'hBF800000, 32'hC0400000, 32'hC1100000, 32'hC1300000};
      run_frame(0, 4, 0, "b2b_f2");

      // Mid-frame reset after beat 7, then a clean frame.
      for (int i = 0; i < 7; i++)
         beat(0, 1'b1, fv[i], (i == 5), 32'h40C00000, 1'b0, "pre_reset");
      rst_n[0] = 1'b0;
      #1;
      last_out[0] = 32'h0;
      chk("in_reset valid_out", 32'(vout[0]), 32'h0);
      chk("in_reset data_out", dout[0], 32'h0);
`ifdef LAYER5_FRAME_DONE_EN
      chk("in_reset frame_done", 32'(fd[0]), 32'h0);
`endif
      @(posedge Clk);
      #1;
      chk("in_reset2 valid_out", 32'(vout[0]), 32'h0);
      rst_n[0] = 1'b1;
      load_basic();
      run_frame(0, 4, 0, "post_reset");

      // Random 4x4 frame against the model, with random gaps.
      pix_q.delete();
      for (int i = 0; i < 16; i++) pix_q.push_back($urandom);
      build_expect(4);
      run_frame(0, 4, -1, "rand4");

      // 2x2 sign and ordering table.
      for (int t = 0; t < 7; t++) begin
         pix_q = '{tbl[t].p0, tbl[t].p1, tbl[t].p2, tbl[t].p3};
         exp_q = '{tbl[t].expv};
         run_frame(1, 2, t % 2, $sformatf("table%0d", t));
      end

      // Full-size random frame against the model.
      pix_q.delete();
      for (int i = 0; i < 104 * 104; i++) begin
         if ($urandom_range(0, 15) == 0 && i > 0)
            pix_q.push_back(pix_q[i-1] ^ {$urandom_range(0, 1) == 1, 31'h0});
         else
            pix_q.push_back($urandom);
      end
      build_expect(104);
      run_frame(2, 104, -1, "full104");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/layer_5_maxpool.md
# layer_5_maxpool

2x2, stride-2 max-pooling stage fed by one layer-4 feature-map output stream. It consumes one fp32 pixel per valid beat in raster order over an IMG_SIZE x IMG_SIZE frame. It emits an (IMG_SIZE/2) x (IMG_SIZE/2) pooled frame in raster order. One instance sits directly downstream of each layer_4_featuremap_N and feeds the layer-6 convolution inputs.

## Interface
- DATA_WIDTH, 32: pixel width, IEEE-754 single precision.
- IMG_SIZE, 104: input frame width and height in pixels. Must be even and at least 2; elaboration fails otherwise.
- Clk  input  1  rising-edge clock.
- Rst  input  1  reset, asynchronous, active-low. One clock; Rst is asynchronous and active-low.
- data_in  input  DATA_WIDTH  input pixel, raster order, row-major.
- valid_in  input  1  data_in is valid this cycle. There is no backpressure; every valid beat is consumed.
- data_out  output  DATA_WIDTH  pooled pixel.
- valid_out  output  1  data_out is valid this cycle; single-cycle pulse per pooled pixel.
- frame_done  output  1  present only with LAYER5_FRAME_DONE_EN (see Configuration).

## Operation
- **Counters**
  - col counts 0..IMG_SIZE-1 and row counts 0..IMG_SIZE-1, both with width $clog2(IMG_SIZE).
  - Both advance only on valid_in.
  - col wraps to 0 after IMG_SIZE-1 and increments row at that point.
  - row wraps to 0 after the last pixel of the frame. The next frame starts with no idle cycle required.
- **Horizontal pair**
  - On even col, data_in is latched into hold_reg.
  - On odd col, hmax = max(hold_reg, data_in), evaluated combinationally.
- **Even row, odd col**
  - hmax is written to line buffer entry col>>1.
  - The line buffer has IMG_SIZE/2 entries of DATA_WIDTH; it is an inferred RAM or register array.
- **Odd row, odd col**
  - data_out is registered with max(linebuf[col>>1], hmax), and valid_out=1 on the next cycle.
  - Otherwise valid_out=0 and data_out holds its last value.
- **fp32 max rule, for bit patterns a and b**
  - If the sign bits differ, the positive operand wins.
  - If both are positive, the larger {exp,mant} wins.
  - If both are negative, the smaller {exp,mant} wins.
  - On equality, including +0 vs -0, the earlier operand wins. For a horizontal pair the earlier operand is hold_reg; for a vertical pair it is linebuf.
  - NaN gets no special handling; the same bitwise rule applies.
- **Gaps:** valid_in may drop for any number of cycles at any point. State, hold_reg and the line buffer are retained across gaps.

## Timing
- Latency: valid_out rises exactly 1 cycle after the valid_in beat carrying the odd-row/odd-col pixel.
- Throughput: at most one output per 2 input beats on odd rows; zero outputs on even rows.
- Each frame produces exactly (IMG_SIZE/2)^2 outputs.
- **Reset, asynchronous assertion:**
  - col=0, row=0, hold_reg=0, data_out=0, valid_out=0, frame_done=0.
  - Line buffer contents are not reset. They are always written on an even row before being read on the following odd row.
- **Reset mid-frame:** the partial frame is discarded and the first valid beat after deassertion is pixel (0,0).
- **Reset deassertion:** takes effect at the next rising Clk. A valid_in on the first edge after deassertion is accepted.

## Configuration
- **Macro:** LAYER5_FRAME_DONE_EN.
- **Defined:**
  - Adds output port frame_done (1 bit, reset 0).
  - frame_done pulses high for 1 cycle, coincident with valid_out for the last pooled pixel of the frame (input pixel row=IMG_SIZE-1, col=IMG_SIZE-1).
- **Undefined:** the frame_done port and its logic are absent. All other behaviour is identical.

## Test plan
- **Basic pool (IMG_SIZE=4):**
  - Stimulus: pixel (r,c) = float(4r+c+1), i.e. 1.0..16.0, continuous valid.
  - Required: outputs 6.0, 8.0, 14.0, 16.0 (0x40C00000, 0x41000000, 0x41600000, 0x41800000), each 1 cycle after input beats 6, 8, 14, 16.
- **Sign handling (IMG_SIZE=2):**
  - Input -1.0, -0.5, -2.0, -3.0 → single output -0.5 (0xBF000000).
  - Input +0, -0, -0, -0 (0x00000000, 0x80000000, 0x80000000, 0x80000000) → output 0x00000000.
- **Gaps:** repeat the basic-pool stimulus with valid_in low for 3 cycles between every beat → identical output values, each 1 cycle after its trigger beat.
- **Back-to-back frames (IMG_SIZE=4):**
  - Stimulus: two frames with no idle cycle, the second frame = first frame negated.
  - Required: second-frame outputs -1.0, -3.0, -9.0, -11.0. With LAYER5_FRAME_DONE_EN, frame_done pulses exactly twice, with the 16.0 and -11.0 outputs.
- **Mid-frame reset:**
  - Stimulus: assert Rst low for 1 cycle after beat 7 of a frame, then restart the frame from 1.0.
  - Required: valid_out=0 and data_out=0 during reset; then outputs 6.0, 8.0, 14.0, 16.0 with no stray output.
- **Full size (IMG_SIZE=104):** random fp32 frame versus a reference model → 2704 outputs match bit-exactly.
